// File: rtl/sha256_round_core.sv
// SHA-256 single-block compression engine with valid/ready on both sides.
// Accepts a 512-bit block plus a 256-bit chaining value, runs 64 rounds at
// UNROLL rounds per clock, then presents the feed-forwarded hash and the tag.
//
// Ports:
//   clk, reset          clock; synchronous active-high reset
//   in_valid/in_ready   input handshake (block, chaining value, tag)
//   data_in             W[0..15], lane i in bits [32i+31:32i]
//   v_in                H[0..7], lane i in bits [32i+31:32i], never byte-swapped
//   tag_in/tag_out      side-band tag carried from accept to result
//   out_valid/out_ready output handshake
//   hash_out            H[i] + final working register i per lane
//   busy                high while rounds are running
module sha256_round_core #(
   parameter int unsigned UNROLL    = 1,
   parameter bit          BYTE_SWAP = 1'b1,
   parameter int unsigned TAG_W     = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [511:0]     data_in,
   input  logic [255:0]     v_in,
   input  logic [TAG_W-1:0] tag_in,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [255:0]     hash_out,
   output logic [TAG_W-1:0] tag_out,
   output logic             busy
);

   if (!(UNROLL == 1 || UNROLL == 2 || UNROLL == 4 || UNROLL == 8)) begin : g_bad_unroll
      $error("sha256_round_core: UNROLL must be 1, 2, 4 or 8");
   end

   localparam int unsigned Steps = 64 / UNROLL;
   localparam int unsigned CntW  = $clog2(Steps);
   localparam logic [CntW-1:0] LastCnt = CntW'(Steps - 1);

   localparam logic [31:0] KTable [64] = '{
      32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
      32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
      32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
      32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
      32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
      32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
      32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
      32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
      32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
      32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
      32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
      32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
      32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
      32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
      32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
      32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
   };

   typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

   function automatic logic [31:0] rotr(input logic [31:0] x, input int unsigned n);
      return (x >> n) | (x << (32 - n));
   endfunction

   function automatic logic [31:0] lane_sw(input logic [31:0] x);
      return BYTE_SWAP ? {x[7:0], x[15:8], x[23:16], x[31:24]} : x;
   endfunction

   function automatic logic [31:0] big_s0(input logic [31:0] x);
      return rotr(x, 2) ^ rotr(x, 13) ^ rotr(x, 22);
   endfunction

   function automatic logic [31:0] big_s1(input logic [31:0] x);
      return rotr(x, 6) ^ rotr(x, 11) ^ rotr(x, 25);
   endfunction

   function automatic logic [31:0] sml_s0(input logic [31:0] x);
      return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
   endfunction

   function automatic logic [31:0] sml_s1(input logic [31:0] x);
      return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
   endfunction

   state_e            state_q, state_d;
   logic [CntW-1:0]   cnt_q, cnt_d;
   logic [31:0]       work_q [8];  // a..h
   logic [31:0]       work_d [8];
   logic [31:0]       v_q [8];
   logic [31:0]       v_d [8];
   logic [31:0]       w_q [16];    // W[t0..t0+15], t0 = first round of this edge
   logic [31:0]       w_d [16];
   logic [TAG_W-1:0]  tag_q, tag_d;
   logic [255:0]      hash_q, hash_d;
   logic [TAG_W-1:0]  tag_out_q, tag_out_d;
   logic              load;

   // Round datapath: UNROLL chained rounds from the current registers.
   logic [31:0] sched [16+UNROLL];
   logic [31:0] rw [8];
   logic [31:0] t1, t2;
   logic [5:0]  rnd;

   always_comb begin
      t1  = '0;
      t2  = '0;
      rnd = '0;
      for (int i = 0; i < 16; i++) sched[i] = w_q[i];
      // Extend the window by UNROLL words so it can shift UNROLL positions.
      for (int j = 0; j < int'(UNROLL); j++) begin
         sched[16+j] = sched[j] + sml_s0(sched[j+1]) + sched[j+9] + sml_s1(sched[j+14]);
      end
      rw = work_q;
      for (int u = 0; u < int'(UNROLL); u++) begin
         rnd   = 6'(int'(cnt_q) * int'(UNROLL) + u);
         t1    = rw[7] + big_s1(rw[4]) + ((rw[4] & rw[5]) ^ (~rw[4] & rw[6]))
                 + KTable[rnd] + sched[u];
         t2    = big_s0(rw[0]) + ((rw[0] & rw[1]) ^ (rw[0] & rw[2]) ^ (rw[1] & rw[2]));
         rw[7] = rw[6];
         rw[6] = rw[5];
         rw[5] = rw[4];
         rw[4] = rw[3] + t1;
         rw[3] = rw[2];
         rw[2] = rw[1];
         rw[1] = rw[0];
         rw[0] = t1 + t2;
      end
   end

   assign in_ready  = (state_q == StIdle) || ((state_q == StDone) && out_ready);
   assign out_valid = (state_q == StDone);
   assign busy      = (state_q == StRun);
   assign hash_out  = hash_q;
   assign tag_out   = tag_out_q;

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      work_d    = work_q;
      v_d       = v_q;
      w_d       = w_q;
      tag_d     = tag_q;
      hash_d    = hash_q;
      tag_out_d = tag_out_q;
      load      = 1'b0;

      unique case (state_q)
         StIdle: begin
            load = in_valid;
         end
         StRun: begin
            cnt_d  = cnt_q + CntW'(1);
            work_d = rw;
            for (int i = 0; i < 16; i++) w_d[i] = sched[i+UNROLL];
            if (cnt_q == LastCnt) begin
               for (int i = 0; i < 8; i++) hash_d[32*i +: 32] = lane_sw(v_q[i] + rw[i]);
               tag_out_d = tag_q;
               state_d   = StDone;
            end
         end
         StDone: begin
            if (out_ready) begin
               state_d = StIdle;
               load    = in_valid;
            end
         end
         default: state_d = StIdle;
      endcase

      // Accept overrides the DONE->IDLE transition when both happen together.
      if (load) begin
         for (int i = 0; i < 8; i++) begin
            work_d[i] = v_in[32*i +: 32];
            v_d[i]    = v_in[32*i +: 32];
         end
         for (int i = 0; i < 16; i++) w_d[i] = lane_sw(data_in[32*i +: 32]);
         tag_d   = tag_in;
         cnt_d   = '0;
         state_d = StRun;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= StIdle;
         cnt_q     <= '0;
         hash_q    <= '0;
         tag_out_q <= '0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         hash_q    <= hash_d;
         tag_out_q <= tag_out_d;
      end
   end

   // Datapath registers need no reset: they are fully loaded on accept.
   always_ff @(posedge clk) begin
      work_q <= work_d;
      v_q    <= v_d;
      w_q    <= w_d;
      tag_q  <= tag_d;
   end

endmodule

// File: tb/tb_sha256_round_core.sv
// Self-checking bench for sha256_round_core: four instances (UNROLL 1/2/4/8,
// the UNROLL=4 one byte-swapped) driven with directed vectors and a reference
// SHA-256 compression model.
module tb_sha256_round_core;

   localparam int NumDut = 4;

   localparam logic [255:0] Iv = {32'h5be0cd19, 32'h1f83d9ab, 32'h9b05688c, 32'h510e527f,
                                  32'ha54ff53a, 32'h3c6ef372, 32'hbb67ae85, 32'h6a09e667};
   localparam logic [255:0] AbcHash = {32'hf20015ad, 32'hb410ff61, 32'h96177a9c, 32'hb00361a3,
                                       32'h5dae2223, 32'h414140de, 32'h8f01cfea, 32'hba7816bf};
   // e3b0c442...7852b855 as a byte stream, byte 0 in bits [7:0].
   localparam logic [255:0] EmptySw = {32'h55b85278, 32'h1b9995a4, 32'h4c939b64, 32'he441ae27,
                                       32'h24b96f99, 32'hc8f4fb9a, 32'h141cfc98, 32'h42c4b0e3};

   localparam logic [31:0] KC [64] = '{
      32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1,
      32'h923f82a4, 32'hab1c5ed5, 32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
      32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174, 32'he49b69c1, 32'hefbe4786,
      32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
      32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147,
      32'h06ca6351, 32'h14292967, 32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
      32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85, 32'ha2bfe8a1, 32'ha81a664b,
      32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
      32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a,
      32'h5b9cca4f, 32'h682e6ff3, 32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
      32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
   };

   logic         clk = 1'b0;
   logic         reset;
   logic [511:0] data_s;
   logic [255:0] v_s;
   logic [31:0]  tag_s;
   logic         in_valid_i  [NumDut];
   logic         out_ready_i [NumDut];
   logic         in_ready_o  [NumDut];
   logic         out_valid_o [NumDut];
   logic         busy_o      [NumDut];
   logic [255:0] hash_o      [NumDut];
   logic [31:0]  tag_o       [NumDut];

   int n_checks = 0;
   int n_errors = 0;

   always #5 clk = ~clk;

   for (genvar g = 0; g < NumDut; g++) begin : g_dut
      sha256_round_core #(
         .UNROLL   (1 << g),
         .BYTE_SWAP(g == 2),
         .TAG_W    (32)
      ) u_dut (
         .clk      (clk),
         .reset    (reset),
         .in_valid (in_valid_i[g]),
         .in_ready (in_ready_o[g]),
         .data_in  (data_s),
         .v_in     (v_s),
         .tag_in   (tag_s),
         .out_valid(out_valid_o[g]),
         .out_ready(out_ready_i[g]),
         .hash_out (hash_o[g]),
         .tag_out  (tag_o[g]),
         .busy     (busy_o[g])
      );
   end

   task automatic check(input string name, input logic [255:0] got, input logic [255:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", name, got, exp);
      end
   endtask

   function automatic logic [31:0] ror32(input logic [31:0] x, input int n);
      return (x >> n) | (x << (32 - n));
   endfunction

   function automatic logic [31:0] bsw(input logic [31:0] x);
      return {x[7:0], x[15:8], x[23:16], x[31:24]};
   endfunction

   function automatic logic [255:0] swap_lanes256(input logic [255:0] x);
      logic [255:0] r;
      for (int i = 0; i < 8; i++) r[32*i +: 32] = bsw(x[32*i +: 32]);
      return r;
   endfunction

   // Reference compression: full 64-entry schedule, then 64 rounds.
   function automatic logic [255:0] sha_ref(input logic [255:0] v, input logic [511:0] d,
                                            input bit sw);
      logic [31:0]  w [64];
      logic [31:0]  a, b, c, e, f, g, h, dd, x1, x2;
      logic [255:0] r;
      for (int i = 0; i < 16; i++) w[i] = sw ? bsw(d[32*i +: 32]) : d[32*i +: 32];
      for (int i = 16; i < 64; i++) begin
         w[i] = w[i-16] + (ror32(w[i-15], 7) ^ ror32(w[i-15], 18) ^ (w[i-15] >> 3))
                + w[i-7] + (ror32(w[i-2], 17) ^ ror32(w[i-2], 19) ^ (w[i-2] >> 10));
      end
      a = v[31:0];    b = v[63:32];   c = v[95:64];   dd = v[127:96];
      e = v[159:128]; f = v[191:160]; g = v[223:192]; h = v[255:224];
      for (int t = 0; t < 64; t++) begin
         x1 = h + (ror32(e, 6) ^ ror32(e, 11) ^ ror32(e, 25)) + ((e & f) ^ (~e & g)) + KC[t] + w[t];
         x2 = (ror32(a, 2) ^ ror32(a, 13) ^ ror32(a, 22)) + ((a & b) ^ (a & c) ^ (b & c));
         h = g; g = f; f = e; e = dd + x1; dd = c; c = b; b = a; a = x1 + x2;
      end
      r = {v[255:224] + h, v[223:192] + g, v[191:160] + f, v[159:128] + e,
           v[127:96] + dd, v[95:64] + c, v[63:32] + b, v[31:0] + a};
      return sw ? swap_lanes256(r) : r;
   endfunction

   function automatic logic [511:0] rand512();
      logic [511:0] r;
      for (int i = 0; i < 16; i++) r[32*i +: 32] = $urandom;
      return r;
   endfunction

   function automatic logic [255:0] rand256();
      logic [255:0] r;
      for (int i = 0; i < 8; i++) r[32*i +: 32] = $urandom;
      return r;
   endfunction

   // Called #1 after the accept edge: counts edges to out_valid, checks, consumes.
   task automatic wait_done(input int g, input string nm, input logic [255:0] exp,
                            input logic [31:0] tg);
      int cyc;
      cyc = 0;
      do begin
         @(posedge clk); #1;
         cyc++;
      end while (!out_valid_o[g] && cyc < 200);
      check({nm, "_latency"}, 256'(cyc), 256'(64 >> g));
      check({nm, "_hash"}, hash_o[g], exp);
      check({nm, "_tag"}, 256'(tag_o[g]), 256'(tg));
      out_ready_i[g] = 1'b1;
      @(posedge clk); #1;
      out_ready_i[g] = 1'b0;
      check({nm, "_consumed"}, 256'(out_valid_o[g]), 256'(0));
   endtask

   task automatic run_block(input int g, input string nm, input logic [511:0] d,
                            input logic [255:0] v, input logic [31:0] tg,
                            input logic [255:0] exp);
      data_s = d; v_s = v; tag_s = tg;
      out_ready_i[g] = 1'b0;
      in_valid_i[g]  = 1'b1;
      @(posedge clk); #1;
      in_valid_i[g] = 1'b0;
      wait_done(g, nm, exp, tg);
   endtask

   logic [511:0] abc_be, abc_le, blk;
   logic [255:0] vv, ex;
   logic [31:0]  tg;
   logic [511:0] sd   [10];
   logic [255:0] sexp [10];

   initial begin
      for (int i = 0; i < NumDut; i++) begin
         in_valid_i[i]  = 1'b0;
         out_ready_i[i] = 1'b0;
      end
      data_s = '0; v_s = '0; tag_s = '0;
      abc_be = {32'h00000018, 448'h0, 32'h61626380};
      abc_le = {32'h18000000, 448'h0, 32'h80636261};
      reset  = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      for (int i = 0; i < NumDut; i++) begin
         check("rst_out_valid", 256'(out_valid_o[i]), 256'(0));
         check("rst_busy", 256'(busy_o[i]), 256'(0));
         check("rst_in_ready", 256'(in_ready_o[i]), 256'(1));
         check("rst_hash", hash_o[i], 256'(0));
         check("rst_tag", 256'(tag_o[i]), 256'(0));
      end
      reset = 1'b0;

      // Known-answer vectors.
      run_block(0, "abc_u1", abc_be, Iv, 32'h12345678, AbcHash);
      run_block(1, "abc_u2", abc_be, Iv, 32'h0badf00d, AbcHash);
      run_block(3, "abc_u8", abc_be, Iv, 32'hcafe0001, AbcHash);
      run_block(2, "abc_u4_sw", abc_le, Iv, 32'h00000042, swap_lanes256(AbcHash));
      run_block(2, "empty_u4_sw", 512'h80, Iv, 32'hdeadbeef, EmptySw);

      // Random blocks and chaining values against the reference model.
      for (int g = 0; g < NumDut; g++) begin
         for (int n = 0; n < 200; n++) begin
            blk = rand512(); vv = rand256(); tg = $urandom;
            run_block(g, "rnd", blk, vv, tg, sha_ref(vv, blk, g == 2));
         end
      end

      // Backpressure on the UNROLL=8 instance.
      blk = rand512(); vv = rand256(); tg = 32'h5a5a0001;
      ex  = sha_ref(vv, blk, 1'b0);
      data_s = blk; v_s = vv; tag_s = tg; in_valid_i[3] = 1'b1;
      @(posedge clk); #1;
      in_valid_i[3] = 1'b0;
      repeat (8) @(posedge clk);
      #1;
      check("bp_valid_rise", 256'(out_valid_o[3]), 256'(1));
      for (int i = 0; i < 20; i++) begin
         in_valid_i[3] = i[0];
         data_s = rand512(); v_s = rand256(); tag_s = $urandom;
         @(posedge clk); #1;
         check("bp_hash_hold", hash_o[3], ex);
         check("bp_tag_hold", 256'(tag_o[3]), 256'(tg));
         check("bp_in_ready", 256'(in_ready_o[3]), 256'(0));
         check("bp_out_valid", 256'(out_valid_o[3]), 256'(1));
      end
      blk = rand512(); vv = rand256(); tg = 32'h5a5a0002;
      data_s = blk; v_s = vv; tag_s = tg;
      in_valid_i[3] = 1'b1; out_ready_i[3] = 1'b1;
      @(posedge clk); #1;
      in_valid_i[3] = 1'b0; out_ready_i[3] = 1'b0;
      check("bp_busy_after", 256'(busy_o[3]), 256'(1));
      check("bp_valid_after", 256'(out_valid_o[3]), 256'(0));
      wait_done(3, "bp_next", sha_ref(vv, blk, 1'b0), tg);

      // Back-to-back streaming, UNROLL=8.
      begin
         int n_acc, n_out, cyc, last;
         bit acc, outv;
         for (int i = 0; i < 10; i++) begin
            sd[i]   = rand512();
            sexp[i] = sha_ref(Iv, sd[i], 1'b0);
         end
         n_acc = 0; n_out = 0; cyc = 0; last = 0;
         data_s = sd[0]; v_s = Iv; tag_s = 32'ha0000000;
         in_valid_i[3] = 1'b1; out_ready_i[3] = 1'b1;
         while (n_out < 10 && cyc < 300) begin
            acc  = in_valid_i[3] && in_ready_o[3];
            outv = out_valid_o[3];
            if (outv) begin
               check("str_hash", hash_o[3], sexp[n_out]);
               check("str_tag", 256'(tag_o[3]), 256'(32'ha0000000 + n_out));
               if (n_out > 0) check("str_spacing", 256'(cyc - last), 256'(9));
               last = cyc;
               n_out++;
            end
            @(posedge clk); #1;
            cyc++;
            if (acc) begin
               n_acc++;
               if (n_acc < 10) begin
                  data_s = sd[n_acc];
                  tag_s  = 32'ha0000000 + n_acc;
               end else begin
                  in_valid_i[3] = 1'b0;
               end
            end
         end
         check("str_count", 256'(n_out), 256'(10));
         in_valid_i[3] = 1'b0; out_ready_i[3] = 1'b0;
      end

      // Reset at round 30 of a RUN on the UNROLL=1 instance.
      data_s = abc_be; v_s = Iv; tag_s = 32'h11110000;
      in_valid_i[0] = 1'b1;
      @(posedge clk); #1;
      in_valid_i[0] = 1'b0;
      repeat (30) @(posedge clk);
      #1;
      check("mid_busy_before", 256'(busy_o[0]), 256'(1));
      reset = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0;
      check("mid_rst_valid", 256'(out_valid_o[0]), 256'(0));
      check("mid_rst_busy", 256'(busy_o[0]), 256'(0));
      check("mid_rst_ready", 256'(in_ready_o[0]), 256'(1));
      check("mid_rst_hash", hash_o[0], 256'(0));
      run_block(0, "mid_after", abc_be, Iv, 32'h11110001, AbcHash);

      // Reset while holding a result in DONE on the UNROLL=8 instance.
      data_s = abc_be; v_s = Iv; tag_s = 32'h22220000;
      in_valid_i[3] = 1'b1;
      @(posedge clk); #1;
      in_valid_i[3] = 1'b0;
      repeat (8) @(posedge clk);
      #1;
      check("done_valid_before", 256'(out_valid_o[3]), 256'(1));
      reset = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0;
      check("done_rst_valid", 256'(out_valid_o[3]), 256'(0));
      check("done_rst_busy", 256'(busy_o[3]), 256'(0));
      check("done_rst_ready", 256'(in_ready_o[3]), 256'(1));
      check("done_rst_hash", hash_o[3], 256'(0));
      check("done_rst_tag", 256'(tag_o[3]), 256'(0));
      run_block(3, "done_after", abc_be, Iv, 32'h22220001, AbcHash);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
